// File: rtl/fft_ctrl_pkg.sv
// fft_ctrl_pkg: shared control types and constants for the 32-point FFT pipeline
package fft_ctrl_pkg;
  localparam int FFT_POINTS = 32;
  localparam int NUM_STAGES = $clog2(FFT_POINTS);
  localparam int STAGE_W = 3;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, HOLD, ERROR} state_t;
endpackage

// File: rtl/fft_watchdog_timer.sv
// fft_watchdog_timer: counts consecutive enabled cycles and flags when TIMEOUT-1 is reached
module fft_watchdog_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] count;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count <= '0;
    else if (clear) count <= '0;
    else if (enable && !expired) count <= count + 1'b1;
  end
  assign expired = count == W'(TIMEOUT - 1);
endmodule

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: launches each FFT stage in turn, waits for its finish, hands the frame downstream
module fft_stage_sequencer import fft_ctrl_pkg::*; #(
  parameter int NUM_STAGES  = fft_ctrl_pkg::NUM_STAGES,
  parameter int TIMEOUT     = 15,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [NUM_STAGES-1:0]  stage_start,
  input  logic [NUM_STAGES-1:0]  stage_finish,
  output logic [2:0]             cur_stage,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   timeout_err,
  input  logic                   err_clear,
  output logic [FRAME_CNT_W-1:0] frame_count
);
  localparam logic [STAGE_W-1:0] LAST = STAGE_W'(NUM_STAGES - 1);
  state_t state, state_n;
  logic [STAGE_W-1:0] stage, stage_n;
  logic finish, expired;
  assign finish = stage_finish[stage];
  fft_watchdog_timer #(.TIMEOUT(TIMEOUT)) u_wdt (
    .clk(clk),
    .reset(reset),
    .clear(state == LAUNCH),
    .enable(state == WAIT),
    .expired(expired)
  );
  always_comb begin
    state_n = state;
    stage_n = stage;
    unique case (state)
      IDLE: if (in_valid) begin
        state_n = LAUNCH;
        stage_n = '0;
      end
      LAUNCH: state_n = WAIT;
      WAIT: if (finish) begin
        state_n = stage == LAST ? HOLD : LAUNCH;
        stage_n = stage == LAST ? stage : stage + 1'b1;
      end else if (expired) state_n = ERROR;
      HOLD: if (out_ready) begin
        state_n = IDLE;
        stage_n = '0;
      end
      ERROR: if (err_clear) begin
        state_n = IDLE;
        stage_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      stage       <= '0;
      frame_count <= '0;
    end else begin
      state <= state_n;
      stage <= stage_n;
      if (state == HOLD && out_ready) frame_count <= frame_count + 1'b1;
    end
  end
  // all outputs decode from registered state so they track an async reset immediately
  assign in_ready    = state == IDLE;
  assign stage_start = state == LAUNCH ? NUM_STAGES'(1) << stage : '0;
  assign cur_stage   = stage;
  assign busy        = state == LAUNCH || state == WAIT;
  assign out_valid   = state == HOLD;
  assign timeout_err = state == ERROR;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: scoreboard bench; expected start/done/error events come from per-frame timing arithmetic
module tb_fft_stage_sequencer;
  localparam int NUM = 5;
  localparam int TIMEOUT = 15;
  localparam int EV_START = 0, EV_DONE = 1, EV_ERR = 2;
  typedef struct {int kind; int stage; int cyc; int fc;} ev_t;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 0, err_clear = 0;
  logic in_ready, busy, out_valid, timeout_err;
  logic [NUM-1:0] stage_start, stage_finish = '0;
  logic [2:0] cur_stage;
  logic [15:0] frame_count;
  ev_t exp_q[$];
  int checks = 0, errors = 0, cyc = 0, fc_model = 0;
  int k[NUM] = '{4, 4, 4, 4, 4};
  int fin_at[NUM] = '{-1, -1, -1, -1, -1};
  int spur_at[2] = '{-1, -1};
  logic [NUM-1:0] spur_mask[2];
  fft_stage_sequencer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .stage_start(stage_start), .stage_finish(stage_finish), .cur_stage(cur_stage),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .timeout_err(timeout_err), .err_clear(err_clear), .frame_count(frame_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask
  task automatic got(input int kind, input int stg);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event_kind", kind, -1);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", kind, e.kind);
    check("event_stage", stg, e.stage);
    check("event_cycle", cyc, e.cyc);
    check("event_cur_stage", int'(cur_stage), e.stage);
    if (kind != EV_START) check("event_frame_count", int'(frame_count), e.fc);
  endtask
  // monitor: compares every observed start, completion and error against the queue
  initial begin
    logic pv, pe;
    int idx;
    pv = 0;
    pe = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (stage_start != '0) begin
          idx = -1;
          for (int i = 0; i < NUM; i++) if (stage_start[i] && idx < 0) idx = i;
          check("start_onehot", $countones(stage_start), 1);
          got(EV_START, idx);
        end
        if (out_valid && !pv) got(EV_DONE, NUM - 1);
        if (timeout_err && !pe) got(EV_ERR, int'(cur_stage));
      end
      pv = out_valid;
      pe = timeout_err;
    end
  end
  // stage models: finish k[i] cycles after start (k<1 never), plus injected spurious pulses
  initial begin
    logic [NUM-1:0] fin;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NUM; i++) begin
        if (reset) fin_at[i] = -1;
        else if (stage_start[i]) fin_at[i] = k[i] < 1 ? -1 : cyc + k[i];
        fin[i] = fin_at[i] == cyc;
        for (int j = 0; j < 2; j++) if (spur_at[j] == cyc && spur_mask[j][i]) fin[i] = 1'b1;
      end
      stage_finish = fin;
    end
  end
  task automatic launch_frame(output int c, output int done, output int es, output int ec);
    int s, t;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_before_accept", int'(in_ready), 1);
    in_valid = 1;
    c = cyc;
    s = c + 1;
    es = -1;
    ec = -1;
    done = -1;
    for (int i = 0; i < NUM; i++) begin
      exp_q.push_back('{EV_START, i, s, fc_model});
      if (k[i] < 1 || k[i] > TIMEOUT) begin
        es = i;
        ec = s + TIMEOUT + 1;
        exp_q.push_back('{EV_ERR, i, ec, fc_model});
        break;
      end
      s += k[i] + 1;
    end
    if (es < 0) begin
      done = s;
      exp_q.push_back('{EV_DONE, NUM - 1, s, fc_model});
    end
  endtask
  task automatic finish_frame(input int done, input int es, input int ec, input int hold, input bit keep, input bit early);
    int h;
    @(negedge clk);
    if (!keep) in_valid = 0;
    out_ready = early;
    err_clear = $urandom_range(0, 1) == 1;
    @(negedge clk);
    err_clear = 0;
    if (es >= 0) begin
      while (cyc < ec + 4) @(negedge clk);
      check("err_held", int'(timeout_err), 1);
      check("err_cur_stage", int'(cur_stage), es);
      check("err_not_busy", int'(busy), 0);
      err_clear = 1;
      @(negedge clk);
      err_clear = 0;
      check("clear_in_ready", int'(in_ready), 1);
      check("clear_timeout_err", int'(timeout_err), 0);
      check("clear_cur_stage", int'(cur_stage), 0);
      check("clear_frame_count", int'(frame_count), fc_model);
    end else begin
      h = early ? done : done + hold;
      while (cyc < h) begin
        @(negedge clk);
        if (cyc >= done && cyc < h) begin
          check("hold_out_valid", int'(out_valid), 1);
          check("hold_in_ready", int'(in_ready), 0);
        end
      end
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      fc_model = (fc_model + 1) & 16'hffff;
      check("post_in_ready", int'(in_ready), 1);
      check("post_out_valid", int'(out_valid), 0);
      check("post_frame_count", int'(frame_count), fc_model);
    end
  endtask
  initial begin
    int c, done, es, ec;
    spur_mask[0] = '0;
    spur_mask[1] = '0;
    #2;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_stage_start", int'(stage_start), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_timeout_err", int'(timeout_err), 0);
    check("rst_cur_stage", int'(cur_stage), 0);
    check("rst_frame_count", int'(frame_count), 0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    k = '{4, 4, 4, 4, 4};
    launch_frame(c, done, es, ec);
    check("basic_done_offset", done - c, 26);
    finish_frame(done, es, ec, 1, 0, 0);
    k = '{4, 4, -1, 4, 4};
    launch_frame(c, done, es, ec);
    finish_frame(done, es, ec, 0, 0, 0);
    k = '{3, 15, 2, 1, 5};
    launch_frame(c, done, es, ec);
    finish_frame(done, es, ec, 2, 0, 0);
    k = '{4, 4, 4, 4, 4};
    launch_frame(c, done, es, ec);
    spur_at[0] = c + 1;
    spur_mask[0] = 5'b00001;
    spur_at[1] = c + 2;
    spur_mask[1] = 5'b01000;
    finish_frame(done, es, ec, 0, 0, 0);
    for (int i = 0; i < NUM; i++) k[i] = $urandom_range(1, 6);
    launch_frame(c, done, es, ec);
    finish_frame(done, es, ec, 10, 1, 0);
    for (int i = 0; i < NUM; i++) k[i] = $urandom_range(1, 6);
    launch_frame(c, done, es, ec);
    finish_frame(done, es, ec, 0, 0, 1);
    for (int n = 0; n < 12; n++) begin
      bit early;
      for (int i = 0; i < NUM; i++) k[i] = $urandom_range(1, TIMEOUT);
      if ($urandom_range(0, 4) == 0) k[$urandom_range(0, NUM - 1)] = $urandom_range(0, 1) == 1 ? TIMEOUT + 1 : -1;
      launch_frame(c, done, es, ec);
      early = es < 0 && $urandom_range(0, 3) == 0;
      finish_frame(done, es, ec, $urandom_range(0, 3), 0, early);
    end
    k = '{4, 4, 4, 4, 4};
    launch_frame(c, done, es, ec);
    @(negedge clk);
    in_valid = 0;
    while (cyc < c + 18) @(negedge clk);
    check("pre_reset_cur_stage", int'(cur_stage), 3);
    check("pre_reset_busy", int'(busy), 1);
    @(posedge clk);
    #2;
    reset = 1;
    #1;
    check("async_in_ready", int'(in_ready), 1);
    check("async_busy", int'(busy), 0);
    check("async_stage_start", int'(stage_start), 0);
    check("async_out_valid", int'(out_valid), 0);
    check("async_timeout_err", int'(timeout_err), 0);
    check("async_cur_stage", int'(cur_stage), 0);
    check("async_frame_count", int'(frame_count), 0);
    exp_q.delete();
    fc_model = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    for (int i = 0; i < NUM; i++) k[i] = $urandom_range(1, 8);
    launch_frame(c, done, es, ec);
    finish_frame(done, es, ec, 1, 0, 0);
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL global_time_limit actual=running required=finished");
    $fatal(1);
  end
endmodule

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

Sequences the five radix-2 stages of the 32-point FFT pipeline for one frame at a time. It accepts a frame over a valid/ready handshake and fires each stage's one-cycle start pulse in order. It waits for that stage's finish pulse, presents a frame-complete handshake to the downstream consumer, and flags any stage that fails to finish within a watchdog window.

## Interface
Parameters:
- NUM_STAGES, 5, number of FFT stages sequenced (log2 of 32)
- TIMEOUT, 15, maximum WAIT cycles allowed per stage before error
- FRAME_CNT_W, 16, width of completed-frame counter

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- in_valid  in  1  upstream has a loaded frame ready to transform
- in_ready  out  1  sequencer idle, frame accepted when in_valid & in_ready
- stage_start  out  NUM_STAGES  one-hot, one-cycle start pulse to stage i
- stage_finish  in  NUM_STAGES  finish pulse from stage i
- cur_stage  out  3  index of stage currently launched/awaited (0 when idle)
- busy  out  1  frame in progress (LAUNCH or WAIT)
- out_valid  out  1  all stages complete, results stable at last-stage outputs
- out_ready  in  1  consumer accepts results
- timeout_err  out  1  watchdog expired; held until err_clear
- err_clear  in  1  acknowledge error, return to IDLE
- frame_count  out  FRAME_CNT_W  frames completed (wraps)

## Operation
- Moore FSM, states IDLE, LAUNCH, WAIT, HOLD, ERROR; outputs decoded from registered state/stage index.
- IDLE: in_ready=1. in_valid&in_ready -> LAUNCH, stage=0.
- LAUNCH (1 cycle): stage_start[stage]=1, watchdog cleared -> WAIT. stage_finish seen in LAUNCH ignored.
- WAIT: only stage_finish[stage] counts; other bits ignored.
  - finish & stage<NUM_STAGES-1 -> stage+1, LAUNCH.
  - finish & stage==NUM_STAGES-1 -> HOLD.
  - no finish & watchdog==TIMEOUT-1 -> ERROR; else watchdog+1.
  - finish and expiry in same cycle: finish wins.
- HOLD: out_valid=1 until out_ready; on handshake frame_count+1 (wraps to 0 after all-ones), stage=0 -> IDLE. Same-cycle new in_valid not accepted (in_ready=0 in HOLD).
- ERROR: timeout_err=1, cur_stage frozen at failing stage, no starts issued. err_clear -> IDLE (frame_count unchanged). err_clear outside ERROR ignored.
- in_valid outside IDLE ignored; out_ready outside HOLD ignored.
- Reset asserted at any time, including mid-frame: state IDLE, stage=0, watchdog=0, frame_count=0, timeout_err=0, stage_start=0, busy=0, out_valid=0, cur_stage=0, in_ready=1 (decoded from IDLE).

## Timing
- Accept at cycle c -> stage_start[0] at c+1.
- Stage finishing k cycles after its start: next stage_start exactly one cycle after finish (gap k+1 per stage).
- With k=4 for all stages: start_i at c+1+5i, last finish c+25, out_valid at c+26.
- Error asserted on cycle after TIMEOUT-th consecutive WAIT cycle without finish.
- Minimum frame-to-frame: out handshake at cycle h -> in_ready at h+1.

## Structure
- Package fft_ctrl_pkg: state enum (IDLE, LAUNCH, WAIT, HOLD, ERROR), FFT_POINTS=32, NUM_STAGES=5, stage-index width constant; shared with the stage wrappers.
- One sub-module: fft_watchdog_timer (clear, enable, expire at TIMEOUT-1), instantiated once.
- FSM, stage index, and frame counter in the top module.

## Test plan
- Reset then in_valid=1 at cycle 0 with stage models finishing 4 cycles after start -> starts at 1,6,11,16,21; out_valid at 26; out_ready at 27 -> frame_count=1, in_ready=1 at 28.
- Stage 2 model never finishes -> timeout_err=1 and cur_stage=2 after 15 WAIT cycles, no stage_start[3]; err_clear -> IDLE, frame_count unchanged.
- Stage 1 finishes on exactly the 15th WAIT cycle -> no error, stage_start[2] next cycle.
- Spurious stage_finish[3] while waiting on stage 0, and finish asserted during LAUNCH -> both ignored, sequence unchanged.
- Hold out_ready=0 for 10 cycles with in_valid=1 -> out_valid stays 1, in_ready stays 0, no new starts; release -> normal restart.
- Assert reset asynchronously mid-WAIT of stage 3 -> all outputs return to reset values without waiting for a clock edge; next frame starts from stage 0.
